// File: rtl/mac_table_nmu_if.sv
// AXI-Stream bundle shared by the TX and RX ports of mac_table_nmu.
// The master drives payload, sideband and tvalid; the slave drives tready.
interface mac_table_nmu_if #(
    parameter int DATA_W = 64,
    parameter int DEST_W = 4
);
    logic [DATA_W-1:0]   tdata;
    logic [DATA_W/8-1:0] tkeep;
    logic                tlast;
    logic                tvalid;
    logic                tready;
    logic [DEST_W-1:0]   tdest;

    modport master (output tdata, tkeep, tlast, tvalid, tdest, input tready);
    modport slave  (input tdata, tkeep, tlast, tvalid, tdest, output tready);
endinterface

// File: rtl/mac_table_nmu.sv
// MAC-table network management unit: TX passthrough, RX tagged with a tdest looked up by destination MAC.
// Define NMU_UNMATCHED_DEFAULT_EN to forward unmatched unicast to DEFAULT_DEST instead of dropping it.
module mac_table_nmu #(
    parameter int AXIS_BUS_WIDTH = 64,
    parameter int AXIS_ID_WIDTH  = 4,
    parameter int NUM_ENTRIES    = 16,
    parameter int MCAST_DEST     = 0,
    parameter int DEFAULT_DEST   = 0,
    parameter int DROP_CNT_WIDTH = 32
) (
    input  logic                      aclk,
    input  logic                      areset,
    mac_table_nmu_if.slave            axis_tx_s,
    mac_table_nmu_if.master           axis_tx_m,
    mac_table_nmu_if.slave            axis_rx_s,
    mac_table_nmu_if.master           axis_rx_m,
    input  logic                      cfg_wr_en,
    input  logic [AXIS_ID_WIDTH-1:0]  cfg_wr_idx,
    input  logic [47:0]               cfg_wr_mac,
    input  logic                      cfg_wr_enable,
    output logic [DROP_CNT_WIDTH-1:0] drop_count
);
    localparam int KW = AXIS_BUS_WIDTH / 8;

    localparam logic [1:0] ST_HEAD = 2'd0;
    localparam logic [1:0] ST_FWD  = 2'd1;
    localparam logic [1:0] ST_DROP = 2'd2;

`ifdef NMU_UNMATCHED_DEFAULT_EN
    localparam bit DROP_EN = 1'b0;
`else
    localparam bit DROP_EN = 1'b1;
`endif

    assign axis_tx_m.tdata  = axis_tx_s.tdata;
    assign axis_tx_m.tkeep  = axis_tx_s.tkeep;
    assign axis_tx_m.tlast  = axis_tx_s.tlast;
    assign axis_tx_m.tvalid = axis_tx_s.tvalid;
    assign axis_tx_m.tdest  = axis_tx_s.tdest;
    assign axis_tx_s.tready = axis_tx_m.tready;

    logic [47:0]            mac_q [NUM_ENTRIES];
    logic [NUM_ENTRIES-1:0] vld_q;

    // NOTE: the table is a small register file that must come up all-invalid, so every entry gets reset.
    always_ff @(posedge aclk) begin
        if (areset) begin
            for (int i = 0; i < NUM_ENTRIES; i++) begin
                mac_q[i] <= '0;
            end
            vld_q <= '0;
        end else if (cfg_wr_en) begin
            for (int i = 0; i < NUM_ENTRIES; i++) begin
                if (cfg_wr_idx == AXIS_ID_WIDTH'(i)) begin
                    mac_q[i] <= cfg_wr_mac;
                    vld_q[i] <= cfg_wr_enable;
                end
            end
        end
    end

    logic [47:0]              dst_mac;
    logic                     hit;
    logic [AXIS_ID_WIDTH-1:0] hit_idx;
    logic [AXIS_ID_WIDTH-1:0] head_dest;
    logic                     head_fwd;

    // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
    always_comb begin
        dst_mac = '0;
        for (int b = 0; b < 6; b++) begin
            dst_mac[47-8*b -: 8] = axis_rx_s.tdata[8*b +: 8];
        end
        hit     = 1'b0;
        hit_idx = '0;
        // Scan downwards so the lowest matching index is the one left standing.
        for (int i = NUM_ENTRIES - 1; i >= 0; i--) begin
            if (vld_q[i] && mac_q[i] == dst_mac) begin
                hit     = 1'b1;
                hit_idx = AXIS_ID_WIDTH'(i);
            end
        end
        head_fwd  = 1'b1;
        head_dest = AXIS_ID_WIDTH'(DEFAULT_DEST);
        if (axis_rx_s.tdata[0]) begin
            head_dest = AXIS_ID_WIDTH'(MCAST_DEST);
        end else if (hit) begin
            head_dest = hit_idx;
        end else begin
            head_fwd = !DROP_EN;
        end
    end

    logic [1:0]                state_q, state_d;
    logic [AXIS_ID_WIDTH-1:0]  dest_q, dest_d;
    logic [DROP_CNT_WIDTH-1:0] cnt_q, cnt_d;
    logic                      m_vld_q, m_vld_d;
    logic [AXIS_BUS_WIDTH-1:0] m_data_q, m_data_d;
    logic [KW-1:0]             m_keep_q, m_keep_d;
    logic                      m_last_q, m_last_d;
    logic [AXIS_ID_WIDTH-1:0]  m_dest_q, m_dest_d;
    logic                      s_ready;
    logic                      accept;
    logic                      emit;

    assign s_ready = (state_q == ST_DROP) || !m_vld_q || axis_rx_m.tready;
    assign accept  = axis_rx_s.tvalid && s_ready;

    always_comb begin
        state_d  = state_q;
        dest_d   = dest_q;
        cnt_d    = cnt_q;
        emit     = 1'b0;
        m_vld_d  = m_vld_q && !axis_rx_m.tready;
        m_data_d = m_data_q;
        m_keep_d = m_keep_q;
        m_last_d = m_last_q;
        m_dest_d = m_dest_q;
        case (state_q)
            ST_HEAD: if (accept) begin
                dest_d = head_dest;
                emit   = head_fwd;
                if (!head_fwd && cnt_q != '1) cnt_d = cnt_q + DROP_CNT_WIDTH'(1);
                if (!axis_rx_s.tlast) state_d = head_fwd ? ST_FWD : ST_DROP;
            end
            ST_FWD: if (accept) begin
                emit = 1'b1;
                if (axis_rx_s.tlast) state_d = ST_HEAD;
            end
            ST_DROP: if (accept && axis_rx_s.tlast) state_d = ST_HEAD;
            default: state_d = ST_HEAD;
        endcase
        if (emit) begin
            m_vld_d  = 1'b1;
            m_data_d = axis_rx_s.tdata;
            m_keep_d = axis_rx_s.tkeep;
            m_last_d = axis_rx_s.tlast;
            m_dest_d = dest_d;
        end
    end

    // NOTE: state registers use non-blocking assignment so every flop samples pre-edge values.
    always_ff @(posedge aclk) begin
        if (areset) begin
            state_q  <= ST_HEAD;
            dest_q   <= '0;
            cnt_q    <= '0;
            m_vld_q  <= 1'b0;
            m_data_q <= '0;
            m_keep_q <= '0;
            m_last_q <= 1'b0;
            m_dest_q <= '0;
        end else begin
            state_q  <= state_d;
            dest_q   <= dest_d;
            cnt_q    <= cnt_d;
            m_vld_q  <= m_vld_d;
            m_data_q <= m_data_d;
            m_keep_q <= m_keep_d;
            m_last_q <= m_last_d;
            m_dest_q <= m_dest_d;
        end
    end

    assign axis_rx_s.tready = s_ready;
    assign axis_rx_m.tvalid = m_vld_q;
    assign axis_rx_m.tdata  = m_data_q;
    assign axis_rx_m.tkeep  = m_keep_q;
    assign axis_rx_m.tlast  = m_last_q;
    assign axis_rx_m.tdest  = m_dest_q;
    assign drop_count       = cnt_q;
endmodule

// File: tb/tb_mac_table_nmu.sv
// Self-checking bench for mac_table_nmu: expected RX beats go into a queue as they are driven
// and an output monitor pops and compares them; scenario tasks check reset, TX, counters and timing.
module tb_mac_table_nmu;
    localparam int W     = 64;
    localparam int KW    = W / 8;
    localparam int IDW   = 4;
    localparam int CW    = 32;
    localparam int MCAST = 7;
    localparam int DFLT  = 9;
`ifdef NMU_UNMATCHED_DEFAULT_EN
    localparam bit DROP_MODE = 1'b0;
`else
    localparam bit DROP_MODE = 1'b1;
`endif

    localparam logic [47:0] MAC3  = 48'h02_00_00_00_00_03;
    localparam logic [47:0] MAC9  = 48'h02_00_00_00_00_09;
    localparam logic [47:0] MACP  = 48'h02_00_00_00_00_15;
    localparam logic [47:0] MACE0 = 48'h02_00_00_00_00_e0;
    localparam logic [47:0] MACE1 = 48'h02_00_00_00_00_e1;
    localparam logic [47:0] MACE2 = 48'h02_00_00_00_00_e2;
    localparam logic [47:0] BCAST = 48'hff_ff_ff_ff_ff_ff;
    localparam logic [47:0] MCGRP = 48'h01_00_5e_00_00_01;

    logic aclk = 1'b0;
    logic areset;
    always #5 aclk = ~aclk;

    mac_table_nmu_if #(.DATA_W(W), .DEST_W(IDW)) tx_s ();
    mac_table_nmu_if #(.DATA_W(W), .DEST_W(IDW)) tx_m ();
    mac_table_nmu_if #(.DATA_W(W), .DEST_W(IDW)) rx_s ();
    mac_table_nmu_if #(.DATA_W(W), .DEST_W(IDW)) rx_m ();

    logic           cfg_wr_en;
    logic [IDW-1:0] cfg_wr_idx;
    logic [47:0]    cfg_wr_mac;
    logic           cfg_wr_enable;
    logic [CW-1:0]  drop_count;

    mac_table_nmu #(
        .AXIS_BUS_WIDTH(W), .AXIS_ID_WIDTH(IDW), .NUM_ENTRIES(16),
        .MCAST_DEST(MCAST), .DEFAULT_DEST(DFLT), .DROP_CNT_WIDTH(CW)
    ) dut (
        .aclk(aclk), .areset(areset),
        .axis_tx_s(tx_s), .axis_tx_m(tx_m), .axis_rx_s(rx_s), .axis_rx_m(rx_m),
        .cfg_wr_en(cfg_wr_en), .cfg_wr_idx(cfg_wr_idx), .cfg_wr_mac(cfg_wr_mac),
        .cfg_wr_enable(cfg_wr_enable), .drop_count(drop_count)
    );

    typedef struct packed {
        logic [W-1:0]   data;
        logic [KW-1:0]  keep;
        logic           last;
        logic [IDW-1:0] dest;
    } beat_t;

    beat_t exp_q[$];
    int    errors = 0;
    int    checks = 0;
    int    cyc = 0;
    bit    rand_ready = 1'b0;

    always @(posedge aclk) cyc <= cyc + 1;

    always @(posedge aclk) begin
        #1;
        rx_m.tready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
    end

    // Output monitor: compares each transfer with the queue head and checks stalled beats stay put.
    beat_t cur, held_b, exp_b;
    bit    held = 1'b0;
    always @(negedge aclk) begin
        cur = '{data: rx_m.tdata, keep: rx_m.tkeep, last: rx_m.tlast, dest: rx_m.tdest};
        if (held) begin
            checks++;
            if (rx_m.tvalid !== 1'b1 || cur !== held_b) begin
                errors++;
                $display("FAIL stall_hold: got valid=%b %h, required valid=1 %h", rx_m.tvalid, cur, held_b);
            end
        end
        held = 1'b0;
        if (rx_m.tvalid === 1'b1 && rx_m.tready === 1'b1) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_out: got dest=%0d data=%h, required no output", cur.dest, cur.data);
            end else begin
                exp_b = exp_q.pop_front();
                if (cur !== exp_b) begin
                    errors++;
                    $display("FAIL rx_beat: got dest=%0d data=%h keep=%h last=%b, required dest=%0d data=%h keep=%h last=%b",
                             cur.dest, cur.data, cur.keep, cur.last, exp_b.dest, exp_b.data, exp_b.keep, exp_b.last);
                end
            end
        end else if (rx_m.tvalid === 1'b1) begin
            held   = 1'b1;
            held_b = cur;
        end
    end

    function automatic logic [W-1:0] mk_beat0(input logic [47:0] mac);
        logic [W-1:0] d;
        d = {$urandom, $urandom};
        for (int b = 0; b < 6; b++) d[8*b +: 8] = mac[47-8*b -: 8];
        return d;
    endfunction

    // Call between a posedge and the following negedge; returns just after the accepting posedge.
    task automatic drive_beat(input logic [W-1:0] d, input logic [KW-1:0] k, input logic l, output int stalls);
        bit done;
        done = 1'b0;
        stalls = 0;
        rx_s.tdata = d; rx_s.tkeep = k; rx_s.tlast = l; rx_s.tvalid = 1'b1;
        for (int n = 0; n < 200 && !done; n++) begin
            @(negedge aclk);
            if (rx_s.tready === 1'b1) begin
                @(posedge aclk);
                #1;
                done = 1'b1;
            end else begin
                stalls++;
            end
        end
        if (!done) begin
            checks++; errors++;
            $display("FAIL beat_accept: got no tready in 200 cycles, required acceptance");
        end
    endtask

    task automatic idle();
        rx_s.tvalid = 1'b0;
        rx_s.tlast  = 1'b0;
    endtask

    task automatic cfg_write(input int idx, input logic [47:0] mac, input logic en);
        cfg_wr_en = 1'b1; cfg_wr_idx = IDW'(idx); cfg_wr_mac = mac; cfg_wr_enable = en;
        @(posedge aclk);
        #1;
        cfg_wr_en = 1'b0;
    endtask

    // inv_at: beat index at which entry 3 is invalidated in the same cycle (-1 for none).
    task automatic send_pkt(input logic [47:0] mac, input int nbeats, input int dest, input bit fwd, input int inv_at);
        beat_t b;
        int    st;
        for (int k = 0; k < nbeats; k++) begin
            b.data = (k == 0) ? mk_beat0(mac) : {$urandom, $urandom};
            b.last = (k == nbeats - 1);
            b.keep = b.last ? 8'h0f : 8'hff;
            b.dest = IDW'(dest);
            if (k == inv_at) begin
                cfg_wr_en = 1'b1; cfg_wr_idx = 4'd3; cfg_wr_mac = MAC3; cfg_wr_enable = 1'b0;
            end
            if (fwd) exp_q.push_back(b);
            drive_beat(b.data, b.keep, b.last, st);
            cfg_wr_en = 1'b0;
            if (!fwd) begin
                checks++;
                if (st !== 0) begin
                    errors++;
                    $display("FAIL drop_ready: got %0d stall cycles on beat %0d, required 0", st, k);
                end
            end
        end
    endtask

    task automatic wait_drain();
        for (int n = 0; n < 300 && exp_q.size() != 0; n++) @(negedge aclk);
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain: got %0d beats outstanding, required 0", exp_q.size());
            exp_q.delete();
        end
        @(posedge aclk);
        #1;
    endtask

    task automatic check_drops(input string name, input int want);
        checks++;
        if (drop_count !== CW'(want)) begin
            errors++;
            $display("FAIL %s: got drop_count=%0d, required %0d", name, drop_count, want);
        end
    endtask

    task automatic test_reset();
        areset = 1'b1;
        repeat (3) @(posedge aclk);
        #1;
        checks++;
        if (rx_m.tvalid !== 1'b0) begin
            errors++; $display("FAIL reset_tvalid: got %b, required 0", rx_m.tvalid);
        end
        checks++;
        if ({rx_m.tdata, rx_m.tkeep, rx_m.tlast, rx_m.tdest} !== '0) begin
            errors++;
            $display("FAIL reset_payload: got data=%h keep=%h last=%b dest=%0d, required all 0",
                     rx_m.tdata, rx_m.tkeep, rx_m.tlast, rx_m.tdest);
        end
        check_drops("reset_drop_count", 0);
        checks++;
        if (rx_s.tready !== 1'b1) begin
            errors++; $display("FAIL reset_s_tready: got %b, required 1", rx_s.tready);
        end
    endtask

    // Runs twice: once with areset held, once after release, since TX ignores reset.
    task automatic test_tx_passthrough();
        logic [W-1:0] d;
        for (int i = 0; i < 2; i++) begin
            d = {$urandom, $urandom};
            tx_s.tdata = d; tx_s.tkeep = KW'(8'ha5 ^ i); tx_s.tlast = i[0]; tx_s.tvalid = 1'b1;
            tx_s.tdest = IDW'(i + 3); tx_m.tready = ~i[0];
            #1;
            checks++;
            if ({tx_m.tdata, tx_m.tkeep, tx_m.tlast, tx_m.tvalid, tx_m.tdest, tx_s.tready}
                !== {d, KW'(8'ha5 ^ i), i[0], 1'b1, IDW'(i + 3), ~i[0]}) begin
                errors++;
                $display("FAIL tx_pass: got data=%h keep=%h last=%b ready=%b, required data=%h keep=%h last=%b ready=%b",
                         tx_m.tdata, tx_m.tkeep, tx_m.tlast, tx_s.tready, d, KW'(8'ha5 ^ i), i[0], ~i[0]);
            end
            areset = 1'b0;
        end
        tx_s.tvalid = 1'b0;
    endtask

    task automatic test_single_match();
        beat_t b;
        int    st;
        cfg_write(3, MAC3, 1'b1);
        for (int k = 0; k < 4; k++) begin
            b.data = (k == 0) ? mk_beat0(MAC3) : {$urandom, $urandom};
            b.last = (k == 3);
            b.keep = 8'hff;
            b.dest = 4'd3;
            exp_q.push_back(b);
            drive_beat(b.data, b.keep, b.last, st);
            idle();
            @(negedge aclk);
            checks++;
            if (rx_m.tvalid !== 1'b1 || rx_m.tdata !== b.data || rx_m.tdest !== 4'd3) begin
                errors++;
                $display("FAIL latency_beat%0d: got valid=%b dest=%0d data=%h one cycle after input, required valid=1 dest=3 data=%h",
                         k, rx_m.tvalid, rx_m.tdest, rx_m.tdata, b.data);
            end
            @(posedge aclk);
            #1;
        end
        wait_drain();
        check_drops("single_drop_count", 0);
    endtask

    task automatic test_priority_mcast();
        cfg_write(1, MACP, 1'b1);
        cfg_write(5, MACP, 1'b1);
        send_pkt(MACP, 2, 1, 1'b1, -1);
        send_pkt(BCAST, 1, MCAST, 1'b1, -1);
        send_pkt(MCGRP, 2, MCAST, 1'b1, -1);
        idle();
        wait_drain();
    endtask

    task automatic test_unmatched();
        send_pkt(MAC9, 3, DFLT, !DROP_MODE, -1);
        idle();
        wait_drain();
        repeat (2) @(posedge aclk);
        #1;
        check_drops("unmatched_drop_count", DROP_MODE ? 1 : 0);
    endtask

    task automatic test_backpressure();
        cfg_write(0, MACE0, 1'b1);
        cfg_write(1, MACE1, 1'b1);
        cfg_write(2, MACE2, 1'b1);
        rand_ready = 1'b1;
        send_pkt(MACE0, 1, 0, 1'b1, -1);
        send_pkt(MACE1, 1, 1, 1'b1, -1);
        send_pkt(MACE2, 1, 2, 1'b1, -1);
        idle();
        wait_drain();
        rand_ready = 1'b0;
        repeat (2) @(posedge aclk);
        #1;
    endtask

    task automatic test_back_to_back();
        int c0, c1;
        c0 = cyc;
        send_pkt(MAC3, 3, 3, 1'b1, -1);
        send_pkt(MACE2, 3, 2, 1'b1, -1);
        c1 = cyc;
        idle();
        checks++;
        if (c1 - c0 !== 6) begin
            errors++;
            $display("FAIL back_to_back: got %0d cycles for 6 beats, required 6", c1 - c0);
        end
        wait_drain();
    endtask

    task automatic test_write_race();
        send_pkt(MAC3, 4, 3, 1'b1, 2);
        idle();
        cfg_write(3, MAC3, 1'b1);
        send_pkt(MAC3, 2, 3, 1'b1, 0);
        send_pkt(MAC3, 2, DFLT, !DROP_MODE, -1);
        idle();
        wait_drain();
        repeat (2) @(posedge aclk);
        #1;
        check_drops("race_drop_count", DROP_MODE ? 2 : 0);
    endtask

    task automatic test_reset_mid();
        beat_t b;
        int    st;
        for (int k = 0; k < 2; k++) begin
            b.data = (k == 0) ? mk_beat0(MACE2) : {$urandom, $urandom};
            b.keep = 8'hff; b.last = 1'b0; b.dest = 4'd2;
            exp_q.push_back(b);
            drive_beat(b.data, b.keep, b.last, st);
        end
        rx_s.tdata = {$urandom, $urandom};
        areset = 1'b1;
        @(posedge aclk);
        #1;
        areset = 1'b0;
        idle();
        @(negedge aclk);
        checks++;
        if (rx_m.tvalid !== 1'b0) begin
            errors++; $display("FAIL midreset_tvalid: got %b, required 0", rx_m.tvalid);
        end
        check_drops("midreset_drop_count", 0);
        @(posedge aclk);
        #1;
        send_pkt(BCAST, 1, MCAST, 1'b1, -1);
        send_pkt(MACE2, 1, DFLT, !DROP_MODE, -1);
        idle();
        wait_drain();
        repeat (2) @(posedge aclk);
        #1;
        check_drops("post_reset_drop_count", DROP_MODE ? 1 : 0);
    endtask

    initial begin
        areset = 1'b1;
        cfg_wr_en = 1'b0; cfg_wr_idx = '0; cfg_wr_mac = '0; cfg_wr_enable = 1'b0;
        tx_s.tdata = '0; tx_s.tkeep = '0; tx_s.tlast = 1'b0; tx_s.tvalid = 1'b0; tx_s.tdest = '0;
        tx_m.tready = 1'b0;
        rx_s.tdata = '0; rx_s.tkeep = '0; rx_s.tlast = 1'b0; rx_s.tvalid = 1'b0; rx_s.tdest = '0;
        test_reset();
        test_tx_passthrough();
        @(posedge aclk);
        #1;
        test_single_match();
        test_priority_mcast();
        test_unmatched();
        test_backpressure();
        test_back_to_back();
        test_write_race();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1, "watchdog");
    end
endmodule
